// File: rtl/axi4_mem_responder_if.sv
// AXI4 bus bundle between the virtual FIFO memory port (master) and the
// block-RAM responder (slave).
interface axi4_mem_responder_if #(
  parameter int TDATA_BYTES = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int ID_WIDTH    = 4
);
  logic                     awvalid;
  logic                     awready;
  logic [ADDR_WIDTH-1:0]    awaddr;
  logic [7:0]               awlen;
  logic [2:0]               awsize;
  logic [1:0]               awburst;
  logic [ID_WIDTH-1:0]      awid;
  logic                     wvalid;
  logic                     wready;
  logic [8*TDATA_BYTES-1:0] wdata;
  logic [TDATA_BYTES-1:0]   wstrb;
  logic                     wlast;
  logic                     bvalid;
  logic                     bready;
  logic [ID_WIDTH-1:0]      bid;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ADDR_WIDTH-1:0]    araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic [ID_WIDTH-1:0]      arid;
  logic                     rvalid;
  logic                     rready;
  logic [8*TDATA_BYTES-1:0] rdata;
  logic [ID_WIDTH-1:0]      rid;
  logic [1:0]               rresp;
  logic                     rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// Block-RAM AXI4 target: independent INCR write and read burst engines over a
// simple dual-port, read-first memory with byte enables.
module axi4_mem_responder #(
  parameter int TDATA_BYTES = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int ID_WIDTH    = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  axi4_mem_responder_if.slave  target
);
  localparam int LO    = $clog2(TDATA_BYTES);
  localparam int IW    = ADDR_WIDTH - LO;
  localparam int DEPTH = 1 << IW;
  localparam int DW    = 8 * TDATA_BYTES;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  function automatic logic supported(input logic [2:0] size, input logic [1:0] burst);
    return (size == 3'(LO)) && (burst == 2'b01);
  endfunction

  logic [DW-1:0] mem [DEPTH];

  w_state_t            w_state;
  logic [IW-1:0]       w_idx;
  logic [7:0]          w_len;
  logic [7:0]          w_beat;
  logic [ID_WIDTH-1:0] w_id;
  logic                w_sup;
  logic                w_err;
  logic                w_err_next;
  logic                mem_we;
  logic                awready;
  logic                wready;
  logic                bvalid;
  logic [1:0]          bresp;

  r_state_t            r_state;
  logic [IW-1:0]       r_idx;
  logic [8:0]          r_rem;
  logic [ID_WIDTH-1:0] r_id;
  logic [1:0]          rresp;
  logic                arready;
  logic                o_valid;
  logic [DW-1:0]       o_data;
  logic                o_last;
  logic                s_valid;
  logic [DW-1:0]       s_data;
  logic                s_last;
  logic                pop;
  logic                issue;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{target.awaddr[LO-1:0], target.araddr[LO-1:0]};

  assign w_err_next = w_err | (target.wlast != (w_beat == w_len));
  assign mem_we     = (w_state == W_DATA) && target.wvalid && wready && w_sup;

  // A RAM read lands directly in the output register, or in the skid entry
  // when the output is stalled; issuing only while the skid is empty
  // guarantees that one of the two has room whatever rready does.
  assign pop   = o_valid && target.rready;
  assign issue = (r_state == R_DATA) && (r_rem != 9'd0) && !s_valid;

  assign target.awready = awready;
  assign target.wready  = wready;
  assign target.bvalid  = bvalid;
  assign target.bid     = w_id;
  assign target.bresp   = bresp;
  assign target.arready = arready;
  assign target.rvalid  = o_valid;
  assign target.rdata   = o_data;
  assign target.rlast   = o_last;
  assign target.rid     = r_id;
  assign target.rresp   = rresp;

  // Write burst engine; the burst always ends on the beat count, wlast only feeds the error flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      w_idx   <= '0;
      w_len   <= 8'd0;
      w_beat  <= 8'd0;
      w_id    <= '0;
      w_sup   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (target.awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            w_idx   <= target.awaddr[ADDR_WIDTH-1:LO];
            w_len   <= target.awlen;
            w_id    <= target.awid;
            w_sup   <= supported(target.awsize, target.awburst);
            w_beat  <= 8'd0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (target.wvalid && wready) begin
            w_idx  <= w_idx + IW'(1);
            w_beat <= w_beat + 8'd1;
            w_err  <= w_err_next;
            if (w_beat == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_sup && !w_err_next) ? 2'b00 : 2'b10;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (target.bready && bvalid) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled memory write port; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < TDATA_BYTES; b++) begin
        if (target.wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= target.wdata[8*b +: 8];
        end
      end
    end
  end

  // Read burst engine with output register and one-entry skid buffer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      r_idx   <= '0;
      r_rem   <= 9'd0;
      r_id    <= '0;
      rresp   <= 2'b00;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_last  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (target.arvalid && arready) begin
            arready <= 1'b0;
            r_idx   <= target.araddr[ADDR_WIDTH-1:LO];
            r_rem   <= {1'b0, target.arlen} + 9'd1;
            r_id    <= target.arid;
            rresp   <= supported(target.arsize, target.arburst) ? 2'b00 : 2'b10;
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (pop && o_last) begin
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
      if (issue) begin
        r_idx <= r_idx + IW'(1);
        r_rem <= r_rem - 9'd1;
      end
      if (s_valid) begin
        if (pop) begin
          o_data  <= s_data;
          o_last  <= s_last;
          s_valid <= 1'b0;
        end
      end else if (!o_valid || pop) begin
        o_valid <= issue;
        if (issue) begin
          o_data <= mem[r_idx];
          o_last <= (r_rem == 9'd1);
        end
      end else if (issue) begin
        s_valid <= 1'b1;
        s_data  <= mem[r_idx];
        s_last  <= (r_rem == 9'd1);
      end
    end
  end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Self-checking bench for axi4_mem_responder: table of write bursts with
// readback through a scoreboard queue, plus hand-written corner sequences.
module tb_axi4_mem_responder;
  localparam int TB  = 8;
  localparam int AW  = 12;
  localparam int IDW = 4;
  localparam int DEPTH = 512;
  localparam int LIM = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_mem_responder_if #(.TDATA_BYTES(TB), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) bus ();
  axi4_mem_responder #(.TDATA_BYTES(TB), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) dut (
    .aclk(clk), .areset(rst), .target(bus)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          bad_last;   // beat carrying the only wlast, -1 for a correct wlast
    bit          odd_strb;   // odd beats write only the low four bytes
    logic [1:0]  exp_bresp;
    bit          readback;
  } vec_t;

  vec_t        vecs [7];
  logic [63:0] model [DEPTH];
  logic [63:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within %0d cycles", nm, LIM);
  endtask

  function automatic logic [63:0] gen(input int v, input int b);
    if (v == 1) return 64'hA5A5_0000_1111_2222;
    return {8'(v), 8'hE0, 16'(b), 32'(v * 4099 + b * 7)};
  endfunction

  task automatic aw_send(input logic [11:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id);
    int g = 0;
    bus.awaddr = a; bus.awlen = l; bus.awsize = s; bus.awburst = b; bus.awid = id;
    bus.awvalid = 1'b1;
    while (!bus.awready && g < LIM) begin @(negedge clk); g++; end
    if (g >= LIM) timeout("aw_handshake");
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [11:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id);
    int g = 0;
    bus.araddr = a; bus.arlen = l; bus.arsize = s; bus.arburst = b; bus.arid = id;
    bus.arvalid = 1'b1;
    while (!bus.arready && g < LIM) begin @(negedge clk); g++; end
    if (g >= LIM) timeout("ar_handshake");
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  task automatic w_send(input int v, input logic [11:0] a, input logic [7:0] l,
                        input int bad_last, input bit odd, input bit sup);
    logic [8:0]  idx;
    logic [63:0] d;
    logic [7:0]  st;
    int          g;
    idx = a[11:3];
    for (int bt = 0; bt <= int'(l); bt++) begin
      g  = 0;
      d  = gen(v, bt);
      st = (odd && (bt % 2 == 1)) ? 8'h0F : 8'hFF;
      bus.wdata = d; bus.wstrb = st;
      bus.wlast = (bad_last >= 0) ? (bt == bad_last) : (bt == int'(l));
      bus.wvalid = 1'b1;
      while (!bus.wready && g < LIM) begin @(negedge clk); g++; end
      if (g >= LIM) timeout("w_handshake");
      if (sup) begin
        for (int k = 0; k < 8; k++) if (st[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      end
      idx++;
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic b_recv(input logic [3:0] id, input logic [1:0] resp);
    int g = 0;
    check("b_valid_after_last_w", 64'(bus.bvalid), 64'd1);
    check("w_ready_after_last_w", 64'(bus.wready), 64'd0);
    bus.bready = 1'b1;
    while (!bus.bvalid && g < LIM) begin @(negedge clk); g++; end
    if (g >= LIM) timeout("b_handshake");
    check("b_id", 64'(bus.bid), 64'(id));
    check("b_resp", 64'(bus.bresp), 64'(resp));
    @(negedge clk);
    bus.bready = 1'b0;
    check("b_valid_drop", 64'(bus.bvalid), 64'd0);
    check("aw_ready_after_b", 64'(bus.awready), 64'd1);
  endtask

  task automatic push_read(input logic [11:0] a, input logic [7:0] l);
    logic [8:0] idx;
    idx = a[11:3];
    for (int bt = 0; bt <= int'(l); bt++) begin
      exp_q.push_back(model[idx]);
      idx++;
    end
  endtask

  task automatic r_collect(input int n, input bit rnd, input logic [3:0] id, input logic [1:0] resp);
    int          got = 0, g = 0, first = -1, gaps = 0;
    bit          stall = 1'b0;
    logic [63:0] pd = 64'd0;
    logic [63:0] e;
    while (got < n && g < LIM) begin
      bus.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) check("r_data_stable", bus.rdata, pd);
      if (bus.rvalid && first < 0) first = g;
      if (!bus.rvalid && got > 0) gaps++;
      if (bus.rvalid && bus.rready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        check("r_data", bus.rdata, e);
        check("r_last", 64'(bus.rlast), 64'(got == n - 1));
        check("r_id", 64'(bus.rid), 64'(id));
        check("r_resp", 64'(bus.rresp), 64'(resp));
        got++;
      end
      stall = bus.rvalid && !bus.rready;
      pd    = bus.rdata;
      @(negedge clk);
      g++;
    end
    bus.rready = 1'b0;
    if (got < n) timeout("r_beats");
    check("r_first_latency", 64'(first), 64'd1);
    if (!rnd) check("r_back_to_back_gaps", 64'(gaps), 64'd0);
    check("r_valid_after_last", 64'(bus.rvalid), 64'd0);
    check("ar_ready_after_last", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.awvalid = 1'b0; bus.awaddr = 12'd0; bus.awlen = 8'd0; bus.awsize = 3'd0;
    bus.awburst = 2'b00; bus.awid = 4'd0; bus.wvalid = 1'b0; bus.wdata = 64'd0;
    bus.wstrb = 8'd0; bus.wlast = 1'b0; bus.bready = 1'b0; bus.arvalid = 1'b0;
    bus.araddr = 12'd0; bus.arlen = 8'd0; bus.arsize = 3'd0; bus.arburst = 2'b00;
    bus.arid = 4'd0; bus.rready = 1'b0;

    vecs[0] = '{12'h000, 8'd255, 3'd3, 2'b01, -1, 1'b0, 2'b00, 1'b0}; // prefill
    vecs[1] = '{12'h010, 8'd0,   3'd3, 2'b01, -1, 1'b0, 2'b00, 1'b1}; // single beat
    vecs[2] = '{12'h000, 8'd255, 3'd3, 2'b01, -1, 1'b1, 2'b00, 1'b1}; // strobed full
    vecs[3] = '{12'hFF0, 8'd3,   3'd3, 2'b01, -1, 1'b0, 2'b00, 1'b1}; // wrap
    vecs[4] = '{12'h100, 8'd3,   3'd3, 2'b00, -1, 1'b0, 2'b10, 1'b1}; // FIXED
    vecs[5] = '{12'h200, 8'd3,   3'd3, 2'b01,  1, 1'b0, 2'b10, 1'b1}; // early wlast
    vecs[6] = '{12'h2A3, 8'd1,   3'd3, 2'b01, -1, 1'b0, 2'b00, 1'b1}; // unaligned

    repeat (3) @(negedge clk);
    check("reset_valids_readies", 64'({bus.awready, bus.wready, bus.bvalid, bus.arready,
                                       bus.rvalid, bus.rlast}), 64'd0);
    check("reset_resps", 64'({bus.bresp, bus.rresp}), 64'd0);
    rst = 1'b0;
    check("aw_ready_at_release", 64'(bus.awready), 64'd0);
    @(negedge clk);
    check("aw_ready_after_release", 64'(bus.awready), 64'd1);
    check("ar_ready_after_release", 64'(bus.arready), 64'd1);

    for (int v = 0; v < 7; v++) begin
      aw_send(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 4'(v));
      check("aw_ready_in_data", 64'(bus.awready), 64'd0);
      check("w_ready_in_data", 64'(bus.wready), 64'd1);
      w_send(v, vecs[v].addr, vecs[v].len, vecs[v].bad_last, vecs[v].odd_strb,
             (vecs[v].size == 3'd3) && (vecs[v].burst == 2'b01));
      b_recv(4'(v), vecs[v].exp_bresp);
      if (vecs[v].readback) begin
        push_read(vecs[v].addr, vecs[v].len);
        ar_send(vecs[v].addr, vecs[v].len, 3'd3, 2'b01, 4'(v + 8));
        r_collect(int'(vecs[v].len) + 1, 1'b0, 4'(v + 8), 2'b00);
      end
    end

    // 256-beat read under random backpressure
    push_read(12'h000, 8'd255);
    ar_send(12'h000, 8'd255, 3'd3, 2'b01, 4'd3);
    r_collect(256, 1'b1, 4'd3, 2'b00);

    // narrow read: one beat, data still returned, SLVERR
    push_read(12'h010, 8'd0);
    ar_send(12'h010, 8'd0, 3'd0, 2'b01, 4'd5);
    r_collect(1, 1'b0, 4'd5, 2'b10);

    // same-cycle write and read of word 0x60 returns the old contents
    exp_q.push_back(model[96]);
    fork
      aw_send(12'h300, 8'd0, 3'd3, 2'b01, 4'd9);
      w_send(20, 12'h300, 8'd0, -1, 1'b0, 1'b1);
      begin
        ar_send(12'h300, 8'd0, 3'd3, 2'b01, 4'd10);
        r_collect(1, 1'b0, 4'd10, 2'b00);
      end
    join
    b_recv(4'd9, 2'b00);
    push_read(12'h300, 8'd0);
    ar_send(12'h300, 8'd0, 3'd3, 2'b01, 4'd11);
    r_collect(1, 1'b0, 4'd11, 2'b00);

    // reset in the middle of a write burst
    aw_send(12'h400, 8'd7, 3'd3, 2'b01, 4'd2);
    bus.wdata = 64'h0123_4567_89AB_CDEF; bus.wstrb = 8'hFF; bus.wlast = 1'b0;
    bus.wvalid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", 64'({bus.awready, bus.wready, bus.bvalid, bus.arready,
                                    bus.rvalid}), 64'd0);
    bus.wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("aw_ready_at_release2", 64'(bus.awready), 64'd0);
    @(negedge clk);
    check("aw_ready_after_release2", 64'(bus.awready), 64'd1);
    aw_send(12'h400, 8'd0, 3'd3, 2'b01, 4'd4);
    w_send(21, 12'h400, 8'd0, -1, 1'b0, 1'b1);
    b_recv(4'd4, 2'b00);
    push_read(12'h400, 8'd0);
    ar_send(12'h400, 8'd0, 3'd3, 2'b01, 4'd6);
    r_collect(1, 1'b0, 4'd6, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
